wb_select_pipe: RTL and testbench

WB_SELECT_PIPE -- requirements
Module: wb_select_pipe

---
 rtl/wb_select_pipe.sv | 144 ++++++++++++++
 tb/tb_wb_select_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_pipe.sv
// ============================================================================
// Module   : wb_select_pipe
// Purpose  : Channel select into a 2-entry ready/valid skid buffer with a
//            sticky out-of-range select flag and an output transfer counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_select_pipe #(
    parameter int WIDTH       = 32,
    parameter int NUM_IN      = 7,
    parameter int SEL_W       = 3,
    parameter int DEFAULT_VAL = 227
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        data_out,
    output logic                    sel_err,
    input  logic                    err_clr,
    output logic [15:0]             xfer_cnt
);

    localparam int               NUM_SLOTS = 2 ** SEL_W;
    localparam logic [WIDTH-1:0] DEF_WORD  = WIDTH'(DEFAULT_VAL);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] oreg_q, oreg_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    logic [WIDTH-1:0]     chan [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] chan_ok;
    logic [WIDTH-1:0]     sel_word;
    logic                 in_xfer;
    logic                 out_xfer;

    // Pad the select space to a full power of two so every sel value is a
    // legal index; padding slots carry the default word and flag an error.
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_chan
        if (k < NUM_IN) begin : g_live
            assign chan[k]    = data_in[k*WIDTH +: WIDTH];
            assign chan_ok[k] = 1'b1;
        end else begin : g_pad
            assign chan[k]    = DEF_WORD;
            assign chan_ok[k] = 1'b0;
        end
    end

    assign sel_word = chan[sel];
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d    = state_q;
        oreg_d     = oreg_q;
        sreg_d     = sreg_q;
        sel_err_d  = sel_err_q;
        xfer_cnt_d = xfer_cnt_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d = ST_ONE;
                    oreg_d  = sel_word;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    oreg_d = sel_word;
                end else if (in_xfer) begin
                    state_d = ST_TWO;
                    sreg_d  = sel_word;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    state_d = ST_ONE;
                    oreg_d  = sreg_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Set wins over a coincident clear.
        if (in_xfer && !chan_ok[sel]) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end

        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end

        in_ready_d  = (state_d == ST_EMPTY) || (state_d == ST_ONE);
        out_valid_d = (state_d == ST_ONE) || (state_d == ST_TWO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            oreg_q      <= '0;
            sreg_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            oreg_q      <= oreg_d;
            sreg_q      <= sreg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = oreg_q;
    assign sel_err   = sel_err_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_select_pipe.sv
// ============================================================================
// Module   : tb_wb_select_pipe
// Purpose  : Directed self-checking bench for wb_select_pipe (default params).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_select_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 7;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] data_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        data_out;
    logic                    sel_err;
    logic                    err_clr;
    logic [15:0]             xfer_cnt;

    int total;
    int bad;

    wb_select_pipe #(
        .WIDTH      (WIDTH),
        .NUM_IN     (NUM_IN),
        .SEL_W      (SEL_W),
        .DEFAULT_VAL(227)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .sel_err  (sel_err),
        .err_clr  (err_clr),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 1ns past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int k, input logic [31:0] v);
        data_in[k*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        for (int k = 0; k < NUM_IN; k++) set_chan(k, 32'h1000_0000 + k);

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_sel_err", {31'd0, sel_err}, 32'd0);
        check("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);

        reset = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        // Single word on channel 2, latency 1
        set_chan(2, 32'hDEADBEEF);
        sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sel2_out_valid", {31'd0, out_valid}, 32'd1);
        check("sel2_data", data_out, 32'hDEADBEEF);
        check("sel2_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("sel2_cnt", {16'd0, xfer_cnt}, 32'd1);
        check("sel2_drained", {31'd0, out_valid}, 32'd0);

        // Out-of-range select gives default and sets the sticky flag
        sel = 3'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("oob_data", data_out, 32'd227);
        check("oob_sel_err", {31'd0, sel_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("oob_clr", {31'd0, sel_err}, 32'd0);
        check("oob_cnt", {16'd0, xfer_cnt}, 32'd2);

        // Set and clear together: set wins
        sel = 3'd7; in_valid = 1'b1; err_clr = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        check("setclr_sel_err", {31'd0, sel_err}, 32'd1);
        tick();
        check("sticky_sel_err", {31'd0, sel_err}, 32'd1);
        check("setclr_cnt", {16'd0, xfer_cnt}, 32'd3);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sticky_clr", {31'd0, sel_err}, 32'd0);

        // Highest legal channel
        sel = 3'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("sel6_data", data_out, 32'h1000_0006);
        check("sel6_no_err", {31'd0, sel_err}, 32'd0);
        tick();
        check("sel6_cnt", {16'd0, xfer_cnt}, 32'd4);

        // Back-pressure: A, B accepted, C held off, then drained in order
        out_ready = 1'b0; sel = 3'd0; in_valid = 1'b1;
        set_chan(0, 32'hAAAA_0001);
        tick();
        check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
        set_chan(0, 32'hBBBB_0002);
        tick();
        check("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_b_data", data_out, 32'hAAAA_0001);
        set_chan(0, 32'hCCCC_0003);
        tick();
        check("bp_c_held_ready", {31'd0, in_ready}, 32'd0);
        check("bp_c_held_data", data_out, 32'hAAAA_0001);
        check("bp_c_held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_out_b", data_out, 32'hBBBB_0002);
        check("bp_cnt_a", {16'd0, xfer_cnt}, 32'd5);
        tick();
        in_valid = 1'b0;
        check("bp_out_c", data_out, 32'hCCCC_0003);
        check("bp_cnt_b", {16'd0, xfer_cnt}, 32'd6);
        tick();
        check("bp_cnt_c", {16'd0, xfer_cnt}, 32'd7);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Clear the counter, then 100 back-to-back transfers
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        check("cnt_cleared", {16'd0, xfer_cnt}, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1; sel = 3'd0;
        for (int i = 0; i < 100; i++) begin
            set_chan(0, 32'h5000_0000 + i);
            tick();
            check("stream_data", data_out, 32'h5000_0000 + i);
            check("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_cnt", {16'd0, xfer_cnt}, 32'd100);

        // Reset with two words buffered
        out_ready = 1'b0; in_valid = 1'b1;
        set_chan(0, 32'h7777_0001);
        tick();
        set_chan(0, 32'h7777_0002);
        tick();
        in_valid = 1'b0;
        check("two_in_ready", {31'd0, in_ready}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        check("midrst_cnt", {16'd0, xfer_cnt}, 32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        check("midrst_held_ready", {31'd0, in_ready}, 32'd0);
        tick();
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("rel_no_stale", {31'd0, out_valid}, 32'd0);
        tick();
        check("rel_no_stale2", {31'd0, out_valid}, 32'd0);
        check("rel_cnt", {16'd0, xfer_cnt}, 32'd0);

        // Counter wrap
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        repeat (65535) tick();
        check("wrap_pre", {16'd0, xfer_cnt}, 32'h0000_FFFF);
        tick();
        check("wrap_zero", {16'd0, xfer_cnt}, 32'd0);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
